// File: rtl/latch_pkg.sv
// Shared types and default sizing for the latch bank.
package latch_pkg;

  typedef enum logic {
    MODE_TRANSPARENT = 1'b0,
    MODE_EDGE        = 1'b1
  } mode_e;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_CHANNELS = 4;
  localparam int unsigned DEF_DEPTH    = 4;

endpackage

// File: rtl/latch_bank_if.sv
// Valid/ready event stream carrying one payload word per transfer.
interface latch_bank_if #(
  parameter int unsigned DW = 8
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/latch_event_fifo.sv
// First-word fall-through event FIFO; a push into a full FIFO without a pop is dropped.
module latch_event_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             drop_c,
  latch_bank_if.master     evt_out
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop, full, empty;

  // Head word is re-registered from the post-update memory image.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    drop_c   = 1'b0;
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    do_pop   = !empty && evt_out.ready;
    do_push  = push && (!full || do_pop);
    drop_c   = push && full && !do_pop;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    valid_d = (count_d != '0);
    head_d  = mem_d[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  assign evt_out.valid = valid_q;
  assign evt_out.data  = head_q;

endmodule

// File: rtl/latch_bank.sv
// Multi-channel bus latch with synchronized strobes, registered readback and a capture-event FIFO.
module latch_bank
  import latch_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned CHANNELS = DEF_CHANNELS,
  parameter int unsigned DEPTH    = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            d,
  input  logic [$clog2(CHANNELS)-1:0] sel,
  input  logic                        le,
  input  logic                        oe_n,
  input  logic                        mode,
  output logic [WIDTH-1:0]            q,
  output logic                        q_oe,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [WIDTH-1:0]            evt_data,
  output logic [$clog2(CHANNELS)-1:0] evt_chan,
  output logic                        ovf,
  input  logic                        ovf_clr
);
  localparam int unsigned SW = $clog2(CHANNELS);
  localparam int unsigned PW = WIDTH + SW;

  logic [1:0]       le_sync_q, le_sync_d;
  logic [1:0]       oe_sync_q, oe_sync_d;
  logic [1:0]       sv_q, sv_d;
  logic             le_d_q, le_d_d;
  logic             arm_q, arm_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] bank_q [CHANNELS];
  logic [WIDTH-1:0] bank_d [CHANNELS];
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_oe_q, q_oe_d;
  logic             ovf_q, ovf_d;
  logic             le_s, oe_s, rise, fall;
  logic             push;
  logic [PW-1:0]    push_data;
  logic             drop_c;

  latch_bank_if #(.DW(PW)) evt_bus ();

  // Edges are only honoured once the synchronizer has seen a genuine low after reset,
  // so a strobe held high across reset release never looks like a fresh capture.
  always_comb begin
    le_s      = le_sync_q[1];
    oe_s      = oe_sync_q[1];
    le_sync_d = {le_sync_q[0], le};
    oe_sync_d = {oe_sync_q[0], oe_n};
    sv_d      = {sv_q[0], 1'b1};
    le_d_d    = le_s;
    arm_d     = arm_q | (sv_q[1] & !le_s);
    mode_d    = mode_e'(mode);
    rise      = arm_q & le_s & !le_d_q;
    fall      = arm_q & !le_s & le_d_q;
    bank_d    = bank_q;
    push      = 1'b0;
    push_data = '0;
    case (mode_q)
      MODE_TRANSPARENT: begin
        if (arm_q && le_s) bank_d[sel] = d;
        if (fall) begin
          push      = 1'b1;
          push_data = {sel, bank_q[sel]};
        end
      end
      MODE_EDGE: begin
        if (rise) begin
          bank_d[sel] = d;
          push        = 1'b1;
          push_data   = {sel, d};
        end
      end
      default: ;
    endcase
    q_d    = oe_s ? '0 : bank_d[sel];
    q_oe_d = !oe_s;
    ovf_d  = drop_c | (ovf_q & !ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      le_sync_q <= 2'b00;
      oe_sync_q <= 2'b11;
      sv_q      <= 2'b00;
      le_d_q    <= 1'b0;
      arm_q     <= 1'b0;
      mode_q    <= MODE_TRANSPARENT;
      for (int i = 0; i < int'(CHANNELS); i++) bank_q[i] <= '0;
      q_q       <= '0;
      q_oe_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      le_sync_q <= le_sync_d;
      oe_sync_q <= oe_sync_d;
      sv_q      <= sv_d;
      le_d_q    <= le_d_d;
      arm_q     <= arm_d;
      mode_q    <= mode_d;
      bank_q    <= bank_d;
      q_q       <= q_d;
      q_oe_q    <= q_oe_d;
      ovf_q     <= ovf_d;
    end
  end

  latch_event_fifo #(.WIDTH(PW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .drop_c    (drop_c),
    .evt_out   (evt_bus)
  );

  assign evt_bus.ready = evt_ready;
  assign evt_valid     = evt_bus.valid;
  assign evt_data      = evt_bus.data[WIDTH-1:0];
  assign evt_chan      = evt_bus.data[PW-1:WIDTH];
  assign q             = q_q;
  assign q_oe          = q_oe_q;
  assign ovf           = ovf_q;

endmodule

// File: tb/tb_latch_bank.sv
// Scoreboard bench for latch_bank: directed captures, overflow, full push/pop and reset discard.
module tb_latch_bank;

  logic       clk = 1'b0;
  logic       rst, le, oe_n, mode, ovf_clr;
  logic [7:0] d;
  logic [1:0] sel;
  logic [7:0] q;
  logic       q_oe, ovf;
  logic [1:0] evt_chan;

  latch_bank_if #(.DW(8)) tb_evt ();

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] exp_q [$];

  always #5 clk = ~clk;

  latch_bank #(.WIDTH(8), .CHANNELS(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .sel       (sel),
    .le        (le),
    .oe_n      (oe_n),
    .mode      (mode),
    .q         (q),
    .q_oe      (q_oe),
    .evt_valid (tb_evt.valid),
    .evt_ready (tb_evt.ready),
    .evt_data  (tb_evt.data),
    .evt_chan  (evt_chan),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] val, input bit expect_evt);
    d = val;
    if (expect_evt) exp_q.push_back({sel, val});
    le = 1'b1;
    tick(4);
    le = 1'b0;
    tick(4);
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (exp_q.size() == 0 && !tb_evt.valid) done = 1'b1;
      else tick(1);
    end
    check({name, "_drained"}, 32'(done), 32'd1);
  endtask

  task automatic monitor();
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (!rst && tb_evt.valid && tb_evt.ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL evt_unexpected: got chan=%0d data=0x%0h expected no event", evt_chan, tb_evt.data);
        end else begin
          e = exp_q.pop_front();
          check("evt_payload", 32'({evt_chan, tb_evt.data}), 32'(e));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; le = 1'b0; oe_n = 1'b1; mode = 1'b0; ovf_clr = 1'b0;
    d = '0; sel = '0; tb_evt.ready = 1'b0;
    fork
      monitor();
    join_none
    tick(3);
    check("rst_q", 32'(q), 32'h0);
    check("rst_q_oe", 32'(q_oe), 32'h0);
    check("rst_evt_valid", 32'(tb_evt.valid), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    rst = 1'b0;
    tick(5);

    // Transparent capture on channel 2 with outputs enabled
    mode = 1'b0; oe_n = 1'b0; sel = 2'd2; d = 8'h5A; tb_evt.ready = 1'b1;
    tick(3);
    exp_q.push_back({2'd2, 8'h5A});
    le = 1'b1;
    tick(6);
    le = 1'b0;
    tick(8);
    check("t0_q", 32'(q), 32'h5A);
    check("t0_q_oe", 32'(q_oe), 32'h1);
    wait_drain("t0");

    // Edge capture ignores d changing while le is high; outputs disabled
    oe_n = 1'b1; mode = 1'b1; sel = 2'd1; d = 8'h11;
    tick(4);
    exp_q.push_back({2'd1, 8'h11});
    le = 1'b1;
    tick(5);
    d = 8'h22;
    tick(5);
    le = 1'b0;
    tick(6);
    check("t1_q_off", 32'(q), 32'h0);
    check("t1_q_oe_off", 32'(q_oe), 32'h0);
    wait_drain("t1");
    oe_n = 1'b0;
    tick(4);
    check("t1_reg1", 32'(q), 32'h11);
    check("t1_q_oe_on", 32'(q_oe), 32'h1);
    sel = 2'd2;
    tick(2);
    check("t1_reg2_kept", 32'(q), 32'h5A);

    // Overflow: five captures into a depth-4 FIFO with no consumer
    tb_evt.ready = 1'b0; sel = 2'd0;
    tick(3);
    for (int i = 1; i <= 5; i++) pulse(8'(i), i <= 4);
    check("t2_ovf_set", 32'(ovf), 32'h1);
    check("t2_valid", 32'(tb_evt.valid), 32'h1);
    check("t2_head", 32'(tb_evt.data), 32'h01);
    tb_evt.ready = 1'b1;
    wait_drain("t2");
    check("t2_ovf_sticky", 32'(ovf), 32'h1);
    tb_evt.ready = 1'b0;
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    tick(1);
    check("t2_ovf_clr", 32'(ovf), 32'h0);

    // Full FIFO: push of 0x77 coincides with a pop of the head
    for (int i = 0; i < 4; i++) pulse(8'h10 + 8'(i), 1'b1);
    d = 8'h77;
    exp_q.push_back({2'd0, 8'h77});
    le = 1'b1;
    tick(2);
    tb_evt.ready = 1'b1;
    tick(1);
    tb_evt.ready = 1'b0;
    tick(2);
    le = 1'b0;
    tick(4);
    check("t3_no_ovf", 32'(ovf), 32'h0);
    check("t3_head", 32'(tb_evt.data), 32'h11);
    pulse(8'h88, 1'b0);
    check("t3_still_full", 32'(ovf), 32'h1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    tb_evt.ready = 1'b1;
    wait_drain("t3");

    // Reset mid-transfer with le held high discards the queue and needs a fresh edge
    tb_evt.ready = 1'b0; mode = 1'b1; sel = 2'd0;
    tick(2);
    for (int i = 0; i < 3; i++) pulse(8'h31 + 8'(i), 1'b1);
    d = 8'h34;
    le = 1'b1;
    tick(5);
    rst = 1'b1;
    tick(2);
    exp_q.delete();
    check("t4_rst_q", 32'(q), 32'h0);
    check("t4_rst_q_oe", 32'(q_oe), 32'h0);
    check("t4_rst_valid", 32'(tb_evt.valid), 32'h0);
    check("t4_rst_ovf", 32'(ovf), 32'h0);
    rst = 1'b0;
    tb_evt.ready = 1'b1;
    tick(12);
    check("t4_no_spurious", 32'(tb_evt.valid), 32'h0);
    le = 1'b0;
    tick(5);
    sel = 2'd3;
    pulse(8'h44, 1'b1);
    wait_drain("t4");
    tick(4);
    check("t4_reg3", 32'(q), 32'h44);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
